// File: rtl/shifter_pipe.sv
// shifter_pipe: pipelined barrel shifter / rotator, one register per level.
// Valid/ready back-pressure, sideband tag pass-through, synchronous flush.
module shifter_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       Flush,
    input  logic                       In_valid,
    output logic                       In_ready,
    input  logic [WIDTH-1:0]           X,
    input  logic [$clog2(WIDTH)-1:0]   Sa,
    input  logic                       Right,
    input  logic                       Arith,
    input  logic                       Rotate,
    input  logic [TAG_W-1:0]           Tag,
    output logic                       Out_valid,
    input  logic                       Out_ready,
    output logic [WIDTH-1:0]           Sh,
    output logic [TAG_W-1:0]           Out_tag
);

    localparam int L = $clog2(WIDTH);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
        logic [L-1:0]     sa;
        logic             right;
        logic             arith;
        logic             rot;
        logic             pad;
        logic [TAG_W-1:0] tag;
    } stage_t;

    stage_t in_s;
    stage_t st_d [L];
    stage_t st_q [L];
    logic   advance;

    // Move d by s positions; vacated bits take pad, or the wrapped bits
    // when rotating. WIDTH is a power of two so the L-bit index wraps.
    function automatic logic [WIDTH-1:0] shift_f(
        input logic [WIDTH-1:0] d,
        input int               s,
        input logic             r,
        input logic             rot,
        input logic             pad
    );
        logic [WIDTH-1:0] o;
        logic [L-1:0]     idx;
        logic             wrap;
        o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (r) begin
                idx  = L'(i + s);
                wrap = (i + s) >= WIDTH;
            end else begin
                idx  = L'(i - s);
                wrap = i < s;
            end
            o[i] = (wrap && !rot) ? pad : d[idx];
        end
        return o;
    endfunction

    // Level k handles the 2^(L-1-k) step, largest step first.
    function automatic stage_t step_f(input stage_t s, input int k);
        stage_t r;
        r = s;
        if (s.sa[L-1-k]) begin
            r.data = shift_f(s.data, 1 << (L-1-k), s.right, s.rot, s.pad);
        end
        return r;
    endfunction

    assign advance  = ~st_q[L-1].valid | Out_ready;
    assign In_ready = advance;

    // Bundle the operand; the fill bit is resolved once here.
    always_comb begin
        in_s       = '0;
        in_s.valid = In_valid;
        in_s.data  = X;
        in_s.sa    = Sa;
        in_s.right = Right;
        in_s.arith = Arith;
        in_s.rot   = Rotate;
        in_s.pad   = X[WIDTH-1] & Right & Arith & ~Rotate;
        in_s.tag   = Tag;
    end

    // Next-state of every level: predecessor moved by this level's step.
    always_comb begin
        st_d[0] = step_f(in_s, 0);
        for (int k = 1; k < L; k++) begin
            st_d[k] = step_f(st_q[k-1], k);
        end
    end

    // Whole pipe advances in lockstep; flush drops every valid, even stalled.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int k = 0; k < L; k++) begin
                st_q[k] <= '0;
            end
        end else if (Flush) begin
            for (int k = 0; k < L; k++) begin
                st_q[k].valid <= 1'b0;
            end
        end else if (advance) begin
            for (int k = 0; k < L; k++) begin
                st_q[k] <= st_d[k];
            end
        end
    end

    assign Out_valid = st_q[L-1].valid;
    assign Sh        = st_q[L-1].data;
    assign Out_tag   = st_q[L-1].tag;

endmodule
